// File: rtl/serial_word_comparator.sv
// Serial magnitude comparator: consumes two operands one digit per accepted
// cycle and keeps a registered less/equal/greater verdict for the open word.
module serial_word_comparator #(
    parameter int DIGIT_W   = 1,
    parameter int MSB_FIRST = 1,
    parameter int SIGNED    = 0,
    parameter int CNT_W     = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               valid,
    input  logic               first,
    input  logic               last,
    input  logic [DIGIT_W-1:0] a,
    input  logic [DIGIT_W-1:0] b,
    output logic               a_less_b,
    output logic               a_eq_b,
    output logic               a_greater_b,
    output logic               done,
    output logic [CNT_W-1:0]   digit_cnt
);

    typedef enum logic [1:0] {
        EQ      = 2'd0,
        LESS    = 2'd1,
        GREATER = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    state_t           base;
    logic             in_word;
    logic             in_word_nxt;
    logic             done_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             start;
    logic             use_signed;
    logic             d_lt;
    logic             d_gt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= EQ;
            in_word   <= 1'b0;
            done      <= 1'b0;
            digit_cnt <= '0;
        end else begin
            state     <= state_nxt;
            in_word   <= in_word_nxt;
            done      <= done_nxt;
            digit_cnt <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        in_word_nxt = in_word;
        done_nxt    = 1'b0;
        cnt_nxt     = digit_cnt;

        // A word opens on first=1 or on any digit following a closed word.
        start = valid && (first || !in_word);
        base  = start ? EQ : state;

        // Only the most significant digit carries the sign.
        use_signed = (SIGNED != 0) &&
                     ((MSB_FIRST != 0) ? start : last);

        if (use_signed) begin
            d_lt = $signed(a) < $signed(b);
            d_gt = $signed(a) > $signed(b);
        end else begin
            d_lt = a < b;
            d_gt = a > b;
        end

        if (valid) begin
            in_word_nxt = !last;
            done_nxt    = last;

            if (start)
                cnt_nxt = CNT_W'(1);
            else if (!(&digit_cnt))
                cnt_nxt = digit_cnt + CNT_W'(1);

            if (MSB_FIRST != 0) begin
                if (base == EQ)
                    state_nxt = d_lt ? LESS : (d_gt ? GREATER : EQ);
                else
                    state_nxt = base;
            end else begin
                state_nxt = d_lt ? LESS : (d_gt ? GREATER : base);
            end
        end
    end

    assign a_less_b    = (state == LESS);
    assign a_eq_b      = (state == EQ);
    assign a_greater_b = (state == GREATER);

endmodule

// File: tb/tb_serial_word_comparator.sv
// Bench for serial_word_comparator: five parameter variants driven together,
// checked each cycle against a whole-word arithmetic model plus literal cases.
module tb_serial_word_comparator;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       valid = 1'b0;
    logic       first = 1'b0;
    logic       last = 1'b0;
    logic       a1 = 1'b0;
    logic       b1 = 1'b0;
    logic [3:0] a4 = '0;
    logic [3:0] b4 = '0;

    logic [4:0] lt;
    logic [4:0] eq;
    logic [4:0] gt;
    logic [4:0] dn;
    logic [7:0] c0, c1, c3, c4;
    logic [2:0] c2;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    // variant 0: W=1 MSB unsigned; 1: W=4 MSB signed; 2: W=4 MSB unsigned
    // with a 3-bit counter; 3: W=4 LSB unsigned; 4: W=4 LSB signed
    int iw[5]   = '{1, 4, 4, 4, 4};
    bit imsb[5] = '{1, 1, 1, 0, 0};
    bit isgn[5] = '{0, 1, 0, 0, 1};
    int imax[5] = '{255, 255, 7, 255, 255};

    serial_word_comparator u0 (
        .clk(clk), .rst(rst), .valid(valid), .first(first), .last(last),
        .a(a1), .b(b1), .a_less_b(lt[0]), .a_eq_b(eq[0]),
        .a_greater_b(gt[0]), .done(dn[0]), .digit_cnt(c0));

    serial_word_comparator #(.DIGIT_W(4), .MSB_FIRST(1), .SIGNED(1)) u1 (
        .clk(clk), .rst(rst), .valid(valid), .first(first), .last(last),
        .a(a4), .b(b4), .a_less_b(lt[1]), .a_eq_b(eq[1]),
        .a_greater_b(gt[1]), .done(dn[1]), .digit_cnt(c1));

    serial_word_comparator #(.DIGIT_W(4), .MSB_FIRST(1), .SIGNED(0),
                             .CNT_W(3)) u2 (
        .clk(clk), .rst(rst), .valid(valid), .first(first), .last(last),
        .a(a4), .b(b4), .a_less_b(lt[2]), .a_eq_b(eq[2]),
        .a_greater_b(gt[2]), .done(dn[2]), .digit_cnt(c2));

    serial_word_comparator #(.DIGIT_W(4), .MSB_FIRST(0), .SIGNED(0)) u3 (
        .clk(clk), .rst(rst), .valid(valid), .first(first), .last(last),
        .a(a4), .b(b4), .a_less_b(lt[3]), .a_eq_b(eq[3]),
        .a_greater_b(gt[3]), .done(dn[3]), .digit_cnt(c3));

    serial_word_comparator #(.DIGIT_W(4), .MSB_FIRST(0), .SIGNED(1)) u4 (
        .clk(clk), .rst(rst), .valid(valid), .first(first), .last(last),
        .a(a4), .b(b4), .a_less_b(lt[4]), .a_eq_b(eq[4]),
        .a_greater_b(gt[4]), .done(dn[4]), .digit_cnt(c4));

    // model state
    logic [3:0] qa1[$], qb1[$], qa4[$], qb4[$];
    bit in_word = 1'b0;
    bit last_flag = 1'b0;
    int cnt_raw = 0;
    int exp_done = 0;
    int exp_res[5] = '{1, 1, 1, 1, 1};

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Compare whole words as integers; only the top digit carries a sign.
    function automatic int word_cmp(int k);
        longint va = 0, vb = 0, da, db, scale = 1, m;
        int n;
        bit sd;
        n = (iw[k] == 1) ? qa1.size() : qa4.size();
        m = longint'(1) << iw[k];
        for (int i = 0; i < n; i++) begin
            if (iw[k] == 1) begin
                da = longint'(qa1[i]);
                db = longint'(qb1[i]);
            end else begin
                da = longint'(qa4[i]);
                db = longint'(qb4[i]);
            end
            sd = isgn[k] && (imsb[k] ? (i == 0) : (last_flag && i == n-1));
            if (sd) begin
                if (da >= m/2) da -= m;
                if (db >= m/2) db -= m;
            end
            if (imsb[k]) begin
                va = va*m + da;
                vb = vb*m + db;
            end else begin
                va += da*scale;
                vb += db*scale;
                scale *= m;
            end
        end
        return (va < vb) ? 0 : ((va == vb) ? 1 : 2);
    endfunction

    function automatic void model_edge();
        if (rst) begin
            qa1.delete(); qb1.delete(); qa4.delete(); qb4.delete();
            in_word = 0;
            cnt_raw = 0;
            exp_done = 0;
            for (int k = 0; k < 5; k++) exp_res[k] = 1;
        end else if (valid) begin
            if (first || !in_word) begin
                qa1.delete(); qb1.delete(); qa4.delete(); qb4.delete();
                cnt_raw = 0;
            end
            qa1.push_back({3'b0, a1});
            qb1.push_back({3'b0, b1});
            qa4.push_back(a4);
            qb4.push_back(b4);
            cnt_raw++;
            last_flag = last;
            in_word = !last;
            exp_done = int'(last);
            for (int k = 0; k < 5; k++) exp_res[k] = word_cmp(k);
        end else begin
            exp_done = 0;
        end
    endfunction

    function automatic int onehot(int r);
        return (r == 0) ? 4 : ((r == 1) ? 2 : 1);
    endfunction

    function automatic int act_cnt(int k);
        case (k)
            0: return int'(c0);
            1: return int'(c1);
            2: return int'(c2);
            3: return int'(c3);
            default: return int'(c4);
        endcase
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 5; k++) begin
                chk($sformatf("flags[%0d]", k),
                    int'({lt[k], eq[k], gt[k]}), onehot(exp_res[k]));
                chk($sformatf("done[%0d]", k), int'(dn[k]), exp_done);
                chk($sformatf("cnt[%0d]", k), act_cnt(k),
                    (cnt_raw > imax[k]) ? imax[k] : cnt_raw);
            end
        end
    end

    task automatic step(bit v, bit f, bit l, logic x1, logic y1,
                        logic [3:0] x4, logic [3:0] y4);
        valid = v; first = f; last = l;
        a1 = x1; b1 = y1; a4 = x4; b4 = y4;
        @(posedge clk);
        model_edge();
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        valid = 1'b1; first = 1'b1; last = 1'b1;
        a1 = 1'b1; b1 = 1'b0; a4 = 4'h9; b4 = 4'h2;
        @(posedge clk);
        model_edge();
        #2;
        rst = 1'b0;
    endtask

    initial begin
        logic [15:0] wa;
        logic [15:0] wb;
        bit v, f, l;
        logic x1, y1;
        logic [3:0] x4, y4;

        do_reset();
        chk_en = 1'b1;
        chk("rst_eq", int'(eq[0]), 1);
        chk("rst_cnt", int'(c0), 0);
        chk("rst_done", int'(dn[0]), 0);

        // 16-digit MSB-first word
        wa = 16'b0100_0001_0010_0110;
        wb = 16'b0100_0110_0100_0110;
        for (int i = 0; i < 16; i++) begin
            step(1, i == 0, i == 15, wa[15-i], wb[15-i], 4'h0, 4'h0);
            if (i == 4) chk("w16_eq5", int'(eq[0]), 1);
            if (i == 5) chk("w16_lt6", int'(lt[0]), 1);
        end
        chk("w16_done", int'(dn[0]), 1);
        chk("w16_lt", int'(lt[0]), 1);
        chk("w16_cnt", int'(c0), 16);
        step(0, 0, 0, 0, 0, 4'h0, 4'h0);
        chk("w16_hold", int'(lt[0]), 1);
        chk("w16_done_off", int'(dn[0]), 0);

        // single-digit words, signed vs unsigned
        step(1, 1, 1, 0, 0, 4'h8, 4'h7);
        chk("s1_lt_signed", int'(lt[1]), 1);
        chk("s1_gt_unsigned", int'(gt[2]), 1);
        chk("s1_done", int'(dn[1] & dn[2]), 1);
        step(0, 0, 0, 0, 0, 4'h0, 4'h0);
        chk("s1_done_once", int'(dn[1] | dn[2]), 0);

        // LSB-first 8'h12 vs 8'h21
        step(1, 1, 0, 0, 0, 4'h2, 4'h1);
        chk("lsb_gt", int'(gt[3]), 1);
        step(1, 0, 1, 0, 0, 4'h1, 4'h2);
        chk("lsb_lt", int'(lt[3]), 1);
        chk("lsb_done", int'(dn[3]), 1);

        // reset mid-word
        for (int i = 0; i < 3; i++) step(1, i == 0, 0, 1, 0, 4'h0, 4'h0);
        chk("pre_rst_gt", int'(gt[0]), 1);
        do_reset();
        chk("mid_rst_eq", int'(eq[0]), 1);
        chk("mid_rst_cnt", int'(c0), 0);
        chk("mid_rst_done", int'(dn[0]), 0);
        step(1, 0, 0, 0, 0, 4'h0, 4'h0);
        chk("post_rst_cnt", int'(c0), 1);
        chk("post_rst_eq", int'(eq[0]), 1);

        // valid gaps
        step(1, 1, 0, 1, 0, 4'h0, 4'h0);
        chk("gap_gt", int'(gt[0]), 1);
        chk("gap_cnt1", int'(c0), 1);
        step(0, 0, 0, 0, 1, 4'h0, 4'h0);
        step(0, 0, 0, 0, 1, 4'h0, 4'h0);
        chk("gap_hold_gt", int'(gt[0]), 1);
        chk("gap_hold_cnt", int'(c0), 1);
        step(1, 0, 0, 0, 0, 4'h0, 4'h0);
        chk("gap_cnt2", int'(c0), 2);
        chk("gap_no_done", int'(dn[0]), 0);

        // abort by first=1
        step(1, 1, 0, 0, 1, 4'h0, 4'h0);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 1, 0, 4'h0, 4'h0);
        chk("abort_lt", int'(lt[0]), 1);
        step(1, 1, 0, 0, 0, 4'h0, 4'h0);
        chk("abort_no_done", int'(dn[0]), 0);
        chk("abort_eq", int'(eq[0]), 1);
        chk("abort_cnt", int'(c0), 1);

        // randomized traffic
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(199) == 0) begin
                do_reset();
            end else begin
                v = $urandom_range(3) != 0;
                f = $urandom_range(9) == 0;
                l = ($urandom_range(4) == 0) ||
                    (in_word && !f && qa4.size() >= 9);
                x1 = 1'($urandom_range(1));
                x4 = 4'($urandom_range(15));
                if ($urandom_range(1) == 0) begin
                    y1 = x1;
                    y4 = x4;
                end else begin
                    y1 = 1'($urandom_range(1));
                    y4 = 4'($urandom_range(15));
                end
                step(v, f, l, x1, y1, x4, y4);
            end
        end

        step(0, 0, 0, 0, 0, 4'h0, 4'h0);
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
